tx_alignment_framer: RTL and testbench
======================================

# tx_alignment_framer

- Transmit-side counterpart of the full-mode RX alignment corrector.
- Drives the 40-bit parallel word into the serializer.
- After reset, or on request, sends a repeating 20-bit training pattern in both halves until the far-end receiver reports alignment. It then sends a sync marker so the receiver can lock the word boundary, and after that streams user data under a valid/ready handshake.
- Idle words fill gaps in user data.

## Interface
Parameters:
- TRAIN_PATTERN, 20'h3E0F8: training half-word. TRAIN_WORD = {TRAIN_PATTERN, TRAIN_PATTERN}.
- SYNC_WORD, 40'hBC0F0_F03BC: boundary marker sent after training.
- IDLE_WORD, 40'h1F07C_1F07C: sent in DATA state when no user word is accepted.
- TRAIN_MIN, 64: minimum training words before SYNC; legal range 1..255.
- SYNC_LEN, 4: consecutive SYNC_WORDs; legal range 1..15.

Ports:
- sys_clk, in, 1: single clock; all logic on the rising edge.
- sys_rst_n, in, 1: asynchronous, active-low reset.
- din, in, 40: user data word.
- din_valid, in, 1: din holds a word.
- din_ready, out, 1: combinational. Equals (state==DATA) & aligned & ~retrain.
- aligned, in, 1: far-end alignment status, already synchronous to sys_clk.
- retrain, in, 1: single-cycle request to restart training.
- dout, out, 40: registered serializer word.
- training, out, 1: registered; high while dout carries TRAIN_WORD or SYNC_WORD.
- link_up, out, 1: registered; high while dout carries data or IDLE_WORD.
- link_drops, out, 8: registered; saturating count of DATA→TRAIN transitions.

## Operation
States are TRAIN, SYNC and DATA. Reset state is TRAIN.

Internal counters:
- train_cnt, 8 bits: counts TRAIN_WORDs emitted, saturates at TRAIN_MIN.
- sync_cnt, 4 bits: counts SYNC_WORDs emitted.

TRAIN state, on each edge:
- dout ← TRAIN_WORD; training ← 1; link_up ← 0; train_cnt increments.
- If train_cnt ≥ TRAIN_MIN-1 (value before the edge) and aligned=1: go to SYNC and set sync_cnt ← 0.
- Otherwise stay in TRAIN. aligned=0 never clears train_cnt while in TRAIN.

SYNC state, on each edge:
- dout ← SYNC_WORD; training ← 1; sync_cnt increments.
- When sync_cnt = SYNC_LEN-1 before the edge: go to DATA.
- If aligned=0: emit TRAIN_WORD on that edge instead, go to TRAIN and set train_cnt ← 1.

DATA state, on each edge:
- If din_valid & din_ready: dout ← din. Otherwise dout ← IDLE_WORD.
- training ← 0; link_up ← 1.
- If aligned=0: go to TRAIN, set train_cnt ← 0, increment link_drops (saturating at 255). That edge emits IDLE_WORD and keeps link_up ← 1, because din_ready was already low.

retrain=1 in any state, with priority over everything else:
- Edge emits TRAIN_WORD; training ← 1; link_up ← 0.
- State ← TRAIN; train_cnt ← 1; sync_cnt ← 0.
- link_drops increments only if leaving DATA.

General rules:
- No user word is ever accepted and dropped. A word is consumed exactly when din_valid & din_ready is high at an edge.
- User data equal to TRAIN_WORD, SYNC_WORD or IDLE_WORD is not escaped; preventing that is the upstream encoder's responsibility.
- Reset values: dout=40'd0, training=0, link_up=0, link_drops=0, state=TRAIN, train_cnt=0, sync_cnt=0. din_ready=0 during reset.
- Reset asserted mid-operation returns every register to these values immediately (asynchronously), regardless of state.

## Timing
Edge numbering: reset released; edge 1 is the first rising edge; aligned held high throughout.
- Edges 1..TRAIN_MIN: TRAIN_WORD.
- Edges TRAIN_MIN+1..TRAIN_MIN+SYNC_LEN: SYNC_WORD.
- din_ready first high in the cycle after edge TRAIN_MIN+SYNC_LEN.
- First user word appears on dout at edge TRAIN_MIN+SYNC_LEN+1, together with link_up=1 and training=0.
- Data latency: a word accepted at edge N appears on dout from N until the next edge (one register stage).
- Throughput: one word per cycle with no bubbles while din_valid and aligned stay high.
- If aligned rises late (after train_cnt has saturated), SYNC begins on the edge where aligned is first sampled high.

## Test plan
- Reset release, aligned=1, TRAIN_MIN=64, SYNC_LEN=4, din_valid=1 with an incrementing counter:
  - 64 × 40'h3E0F8_3E0F8, then 4 × SYNC_WORD.
  - The counter from value 0 appears at edge 69 with no gaps; link_up rises at edge 69.
- aligned=0 until edge 100:
  - TRAIN_WORD for 100 edges, then SYNC at edge 101.
  - din_ready stays 0 throughout.
- In DATA with din_valid toggling every other cycle:
  - dout alternates data and IDLE_WORD.
  - Every accepted word appears exactly once, in order.
- aligned drops for 1 cycle in DATA with din_valid=1:
  - That edge emits IDLE_WORD and no word is consumed.
  - link_drops goes 0→1; 64 TRAIN_WORDs follow, then SYNC, then the same pending din word.
- aligned drops during SYNC (after 2 SYNC words):
  - Next word is TRAIN_WORD; link_drops unchanged.
  - A full 64-word training period passes before SYNC returns.
- retrain pulse in DATA, and sys_rst_n asserted mid-SYNC:
  - retrain: next edge emits TRAIN_WORD and link_drops increments.
  - Reset: dout=0, training=0, link_up=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/tx_alignment_framer.sv
// Transmit-side alignment framer: sends training words until the far end aligns,
// then a sync marker burst, then user data (or idle fill) under valid/ready.
module tx_alignment_framer #(
  parameter logic [19:0] TRAIN_PATTERN = 20'h3E0F8,
  parameter logic [39:0] SYNC_WORD     = 40'hBC0F0_F03BC,
  parameter logic [39:0] IDLE_WORD     = 40'h1F07C_1F07C,
  parameter int unsigned TRAIN_MIN     = 64,
  parameter int unsigned SYNC_LEN      = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [39:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        aligned,
  input  logic        retrain,
  output logic [39:0] dout,
  output logic        training,
  output logic        link_up,
  output logic [7:0]  link_drops
);

  localparam int unsigned DW = 40;
  localparam int unsigned CW = 8;
  localparam int unsigned SW = 4;

  localparam logic [DW-1:0] TRAIN_WORD = {TRAIN_PATTERN, TRAIN_PATTERN};
  localparam logic [CW-1:0] TRAIN_LAST = CW'(TRAIN_MIN - 1);
  localparam logic [CW-1:0] TRAIN_SAT  = CW'(TRAIN_MIN);
  localparam logic [SW-1:0] SYNC_LAST  = SW'(SYNC_LEN - 1);

  localparam logic [1:0] S_TRAIN = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;

  logic [1:0]    r_state;
  logic [DW-1:0] r_dout;
  logic          r_training;
  logic          r_link_up;
  logic [CW-1:0] r_link_drops;
  logic [CW-1:0] r_train_cnt;
  logic [SW-1:0] r_sync_cnt;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_dout_nxt;
  logic          w_training_nxt;
  logic          w_link_up_nxt;
  logic [CW-1:0] w_link_drops_nxt;
  logic [CW-1:0] w_train_cnt_nxt;
  logic [SW-1:0] w_sync_cnt_nxt;
  logic [CW-1:0] w_drops_inc;
  logic [CW-1:0] w_train_inc;
  logic          w_ready;
  logic          w_accept;

  assign w_ready    = (r_state == S_DATA) & aligned & ~retrain;
  assign w_accept   = din_valid & w_ready;
  assign din_ready  = w_ready;
  assign w_drops_inc = (r_link_drops == 8'hFF) ? r_link_drops : r_link_drops + 8'd1;
  assign w_train_inc = (r_train_cnt < TRAIN_SAT) ? r_train_cnt + 8'd1 : r_train_cnt;

  // Next-state and next-output logic; retrain overrides every state.
  always_comb begin
    w_state_nxt      = r_state;
    w_dout_nxt       = r_dout;
    w_training_nxt   = r_training;
    w_link_up_nxt    = r_link_up;
    w_link_drops_nxt = r_link_drops;
    w_train_cnt_nxt  = r_train_cnt;
    w_sync_cnt_nxt   = r_sync_cnt;

    if (retrain) begin
      w_state_nxt     = S_TRAIN;
      w_dout_nxt      = TRAIN_WORD;
      w_training_nxt  = 1'b1;
      w_link_up_nxt   = 1'b0;
      w_train_cnt_nxt = 8'd1;
      w_sync_cnt_nxt  = 4'd0;
      if (r_state == S_DATA) w_link_drops_nxt = w_drops_inc;
    end else begin
      case (r_state)
        S_TRAIN: begin
          w_dout_nxt      = TRAIN_WORD;
          w_training_nxt  = 1'b1;
          w_link_up_nxt   = 1'b0;
          w_train_cnt_nxt = w_train_inc;
          if ((r_train_cnt >= TRAIN_LAST) && aligned) begin
            w_state_nxt    = S_SYNC;
            w_sync_cnt_nxt = 4'd0;
          end
        end
        S_SYNC: begin
          w_training_nxt = 1'b1;
          w_link_up_nxt  = 1'b0;
          if (!aligned) begin
            // Lost alignment mid-marker: this word already counts as training.
            w_state_nxt     = S_TRAIN;
            w_dout_nxt      = TRAIN_WORD;
            w_train_cnt_nxt = 8'd1;
            w_sync_cnt_nxt  = 4'd0;
          end else begin
            w_dout_nxt     = SYNC_WORD;
            w_sync_cnt_nxt = r_sync_cnt + 4'd1;
            if (r_sync_cnt == SYNC_LAST) w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_dout_nxt     = w_accept ? din : IDLE_WORD;
          w_training_nxt = 1'b0;
          w_link_up_nxt  = 1'b1;
          if (!aligned) begin
            w_state_nxt      = S_TRAIN;
            w_train_cnt_nxt  = 8'd0;
            w_link_drops_nxt = w_drops_inc;
          end
        end
        default: begin
          w_state_nxt     = S_TRAIN;
          w_dout_nxt      = TRAIN_WORD;
          w_training_nxt  = 1'b1;
          w_link_up_nxt   = 1'b0;
          w_train_cnt_nxt = 8'd0;
          w_sync_cnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_TRAIN;
      r_dout       <= 40'd0;
      r_training   <= 1'b0;
      r_link_up    <= 1'b0;
      r_link_drops <= 8'd0;
      r_train_cnt  <= 8'd0;
      r_sync_cnt   <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_dout       <= w_dout_nxt;
      r_training   <= w_training_nxt;
      r_link_up    <= w_link_up_nxt;
      r_link_drops <= w_link_drops_nxt;
      r_train_cnt  <= w_train_cnt_nxt;
      r_sync_cnt   <= w_sync_cnt_nxt;
    end
  end

  assign dout       = r_dout;
  assign training   = r_training;
  assign link_up    = r_link_up;
  assign link_drops = r_link_drops;

endmodule

// File: tb/tb_tx_alignment_framer.sv
// Directed bench for tx_alignment_framer: training/sync sequencing, data flow,
// alignment loss, retrain and asynchronous reset.
module tb_tx_alignment_framer;

  localparam logic [39:0] TRAIN_W = 40'h3E0F8_3E0F8;
  localparam logic [39:0] SYNC_W  = 40'hBC0F0_F03BC;
  localparam logic [39:0] IDLE_W  = 40'h1F07C_1F07C;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [39:0] din;
  logic        din_valid;
  logic        din_ready;
  logic        aligned;
  logic        retrain;
  logic [39:0] dout;
  logic        training;
  logic        link_up;
  logic [7:0]  link_drops;

  int n_checks;
  int n_fail;
  logic [39:0] tx_word;

  tx_alignment_framer dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .aligned    (aligned),
    .retrain    (retrain),
    .dout       (dout),
    .training   (training),
    .link_up    (link_up),
    .link_drops (link_drops)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle outputs.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic expect_train(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, " dout"}, dout, TRAIN_W);
      check({tag, " training"}, 40'(training), 40'd1);
      check({tag, " link_up"}, 40'(link_up), 40'd0);
      check({tag, " din_ready"}, 40'(din_ready), 40'd0);
    end
  endtask

  task automatic expect_sync(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, " dout"}, dout, SYNC_W);
      check({tag, " training"}, 40'(training), 40'd1);
      check({tag, " link_up"}, 40'(link_up), 40'd0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sys_rst_n = 1'b0;
    din       = 40'd0;
    din_valid = 1'b0;
    aligned   = 1'b0;
    retrain   = 1'b0;
    tx_word   = 40'd0;

    repeat (3) @(posedge sys_clk);
    #1;
    check("rst dout", dout, 40'd0);
    check("rst training", 40'(training), 40'd0);
    check("rst link_up", 40'(link_up), 40'd0);
    check("rst drops", 40'(link_drops), 40'd0);
    check("rst din_ready", 40'(din_ready), 40'd0);

    // Nominal bring-up with aligned high from the start.
    aligned   = 1'b1;
    din_valid = 1'b1;
    din       = tx_word;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    expect_train(64, "up train");
    expect_sync(4, "up sync");
    check("up ready after sync", 40'(din_ready), 40'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("up data", dout, tx_word);
      check("up link_up", 40'(link_up), 40'd1);
      check("up training", 40'(training), 40'd0);
      tx_word = tx_word + 40'd1;
      din     = tx_word;
    end

    // din_valid toggling: data and idle alternate, each word exactly once.
    for (int i = 0; i < 8; i++) begin
      din_valid = (i % 2 == 1);
      tick();
      if (i % 2 == 1) begin
        check("toggle data", dout, tx_word);
        tx_word = tx_word + 40'd1;
        din     = tx_word;
      end else begin
        check("toggle idle", dout, IDLE_W);
      end
    end

    // One-cycle alignment loss in DATA with a pending word.
    din_valid = 1'b1;
    aligned   = 1'b0;
    #1;
    check("drop din_ready", 40'(din_ready), 40'd0);
    tick();
    check("drop dout idle", dout, IDLE_W);
    check("drop link_up", 40'(link_up), 40'd1);
    check("drop training", 40'(training), 40'd0);
    check("drop count", 40'(link_drops), 40'd1);
    aligned = 1'b1;
    expect_train(64, "drop train");
    expect_sync(4, "drop sync");
    tick();
    check("drop pending word", dout, tx_word);
    tx_word = tx_word + 40'd1;
    din     = tx_word;
    tick();
    check("drop next word", dout, tx_word);
    tx_word = tx_word + 40'd1;
    din     = tx_word;

    // Retrain pulse in DATA.
    retrain = 1'b1;
    #1;
    check("retrain din_ready", 40'(din_ready), 40'd0);
    tick();
    check("retrain dout", dout, TRAIN_W);
    check("retrain training", 40'(training), 40'd1);
    check("retrain link_up", 40'(link_up), 40'd0);
    check("retrain drops", 40'(link_drops), 40'd2);
    retrain = 1'b0;
    expect_train(63, "retrain train");
    expect_sync(2, "retrain sync");

    // Alignment lost after two SYNC words.
    aligned = 1'b0;
    tick();
    check("syncdrop dout", dout, TRAIN_W);
    check("syncdrop training", 40'(training), 40'd1);
    check("syncdrop drops", 40'(link_drops), 40'd2);
    aligned = 1'b1;
    expect_train(63, "syncdrop train");
    expect_sync(2, "syncdrop sync");

    // Asynchronous reset mid-SYNC, checked before any clock edge.
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("async rst dout", dout, 40'd0);
    check("async rst training", 40'(training), 40'd0);
    check("async rst link_up", 40'(link_up), 40'd0);
    check("async rst drops", 40'(link_drops), 40'd0);
    check("async rst din_ready", 40'(din_ready), 40'd0);

    // Late alignment: sampled high first at edge 100.
    aligned = 1'b0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int e = 1; e <= 100; e++) begin
      aligned = (e == 100);
      tick();
      check("late train dout", dout, TRAIN_W);
      check("late din_ready", 40'(din_ready), 40'd0);
    end
    tick();
    check("late sync at 101", dout, SYNC_W);
    check("late training", 40'(training), 40'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
